mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive cycles one grant is held; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4, request per requester; bit i is requester i.
REQ-005 SHALL have port d, input, 4, data bit per requester, mapping d[0..3] to mux inputs I0..I3.
REQ-006 SHALL have port gnt, output, 4, registered one-hot grant; all-zero when idle.
REQ-007 SHALL have port sel, output, 2, registered mux select {S1,S0}, equal to the index of the granted requester.
REQ-008 SHALL have port valid, output, 1, registered; high exactly when gnt is non-zero.
REQ-009 SHALL have port y, output, 1, selected data: d[sel] when valid is high, else 0.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0000, valid = 0 and sel holding its last value.
REQ-012 In IDLE with any req bit set at edge N, SHALL grant the first set bit in round-robin order starting at (last_idx+1) mod 4 and enter GRANT; gnt, sel and valid become visible after edge N (one-cycle latency).
REQ-013 In GRANT, SHALL keep gnt, sel and last_idx unchanged while req[sel] = 1 and hold_cnt < MAX_HOLD-1, incrementing hold_cnt every cycle.
REQ-014 SHALL release the current grant at an edge where req[sel] = 0 (drop) or hold_cnt = MAX_HOLD-1 (expiry).
REQ-015 On release with at least one other req bit set, SHALL grant the next set bit in round-robin order after sel at that same edge, with no idle bubble, and clear hold_cnt to 0.
REQ-016 On expiry where req[sel] is the only set bit, SHALL re-grant the same requester with no bubble and clear hold_cnt to 0.
REQ-017 On drop with req == 0, SHALL enter IDLE, clear gnt and valid, and clear hold_cnt.
REQ-018 SHALL update last_idx to the granted index on every grant or re-grant.
REQ-019 SHALL ensure gnt is always 0000 or exactly one-hot, and that gnt[sel] = 1 whenever valid = 1.
REQ-020 SHALL make y purely combinational from d, sel and valid, so that a change on the selected d bit appears on y in the same cycle and a change on an unselected d bit has no effect on y.
REQ-021 SHALL size hold_cnt as a 4-bit counter; with MAX_HOLD = 1, every cycle SHALL be an expiry.
REQ-022 SHALL treat a req bit deasserting for a requester that is not granted as having no effect on the current grant.

Reset
REQ-023 On rst_n low, SHALL immediately, without waiting for a clock edge, force state = IDLE, gnt = 0000, sel = 00, valid = 0, y = 0, hold_cnt = 0 and last_idx = 3, so that requester 0 has first priority.
REQ-024 On rst_n assertion during GRANT, SHALL abandon the grant immediately; after release, the first grant SHALL follow REQ-012 with requester 0 highest priority.

Verification
REQ-025 Bench SHALL drive rst_n = 0 then 1, d = 1010, req = 0001 -> after the next edge, gnt = 0001, sel = 00, valid = 1, y = 0; with req = 0100 instead, y = 0 (I2 = 0).
REQ-026 Bench SHALL hold req = 1111 with MAX_HOLD = 8 -> gnt visits 0001, 0010, 0100, 1000, 0001, each for exactly 8 cycles, with no bubbles.
REQ-027 Bench SHALL grant requester 1, then drop req[1] with req[3] = 1 -> at the next edge gnt = 1000 and sel = 11, with valid staying 1.
REQ-028 Bench SHALL hold req = 0100 for 20 cycles -> gnt = 0100 continuously and hold_cnt wraps at 7 twice; then drop req to 0000 -> valid = 0 at the next edge.
REQ-029 Bench SHALL grant requester 2 with d = 1010, set d[2] = 1 -> y = 1 in the same cycle; then set d[0] = 1 -> y unchanged.
REQ-030 Bench SHALL assert rst_n = 0 mid-grant at a non-edge time -> gnt = 0000 and sel = 00 immediately; after release with req = 1001 -> gnt = 0001.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 4:1 mux select.
// Grants are registered and held for at most MAX_HOLD cycles before rotating.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;
  logic [1:0] pick_s;
  logic       y_s;

  // First set bit of r scanning upward from start, wrapping mod 4; caller guarantees r != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Next-state: hold, rotate on drop/expiry, or fall back to idle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    last_d  = last_q;
    pick_s  = 2'd0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          pick_s  = rr_pick(req, last_q + 2'd1);
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_s;
          sel_d   = pick_s;
          valid_d = 1'b1;
          hold_d  = 4'd0;
          last_d  = pick_s;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (req[sel_q] && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + 4'd1;
        end else if (req != 4'b0000) begin
          // Scanning from sel+1 wraps back to sel itself when it is the only requester.
          pick_s  = rr_pick(req, sel_q + 2'd1);
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_s;
          sel_d   = pick_s;
          valid_d = 1'b1;
          hold_d  = 4'd0;
          last_d  = pick_s;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = 4'd0;
      end
    endcase
  end

  // State and output registers; last_q resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      hold_q  <= 4'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Combinational mux output, forced low while nothing is granted.
  always_comb begin
    y_s = 1'b0;
    if (valid_q) begin
      y_s = d[sel_q];
    end else begin
      y_s = 1'b0;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = y_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed + random bench for mux4_rr_arbiter, checking MAX_HOLD=8 and MAX_HOLD=1
// instances against a cycle-counting round-robin reference model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt_o   [2];
  logic [1:0] sel_o   [2];
  logic       valid_o [2];
  logic       y_o     [2];

  int n_pass  = 0;
  int n_total = 0;

  // reference model state per instance
  int mh       [2] = '{8, 1};
  int m_owner  [2];
  int m_cycles [2];
  int m_last   [2];
  int m_sel    [2];

  mux4_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .valid(valid_o[0]), .y(y_o[0])
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .valid(valid_o[1]), .y(y_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u]  = -1;
      m_cycles[u] = 0;
      m_last[u]   = 3;
      m_sel[u]    = 0;
    end
  endtask

  // One clock edge of the arbitration rules, with the requests seen at that edge.
  task automatic model_step(input logic [3:0] r);
    int start;
    int idx;
    bit found;
    for (int u = 0; u < 2; u++) begin
      if (m_owner[u] >= 0 && r[m_owner[u]] && m_cycles[u] < mh[u]) begin
        m_cycles[u]++;
      end else begin
        start = (m_owner[u] >= 0) ? m_owner[u] + 1 : m_last[u] + 1;
        m_owner[u]  = -1;
        m_cycles[u] = 0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          idx = (start + k) % 4;
          if (!found && r[idx]) begin
            found       = 1'b1;
            m_owner[u]  = idx;
            m_cycles[u] = 1;
            m_last[u]   = idx;
            m_sel[u]    = idx;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    logic       ev;
    logic       ey;
    for (int u = 0; u < 2; u++) begin
      eg = (m_owner[u] >= 0) ? (4'b0001 << m_owner[u]) : 4'b0000;
      ev = (m_owner[u] >= 0);
      ey = ev ? d[m_sel[u]] : 1'b0;
      chk($sformatf("%s_u%0d_gnt", tag, u), gnt_o[u], eg);
      chk($sformatf("%s_u%0d_sel", tag, u), {2'b00, sel_o[u]}, 4'(m_sel[u]));
      chk($sformatf("%s_u%0d_valid", tag, u), {3'b000, valid_o[u]}, {3'b000, ev});
      chk($sformatf("%s_u%0d_y", tag, u), {3'b000, y_o[u]}, {3'b000, ey});
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(req);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    d     = 4'b0000;
    model_reset();
    #1 rst_n = 1'b0;
    #3;
    check_model("reset");
    chk("reset_gnt", gnt_o[0], 4'b0000);
    #4 rst_n = 1'b1;

    // single request from reset: requester 0, y follows I0 = 0
    d   = 4'b1010;
    req = 4'b0001;
    cycle("r25a");
    chk("r25_gnt0", gnt_o[0], 4'b0001);
    chk("r25_y0", {3'b000, y_o[0]}, 4'b0000);
    req = 4'b0000;
    cycle("r25idle");
    req = 4'b0100;
    cycle("r25b");
    chk("r25_gnt2", gnt_o[0], 4'b0100);
    chk("r25_y2", {3'b000, y_o[0]}, 4'b0000);

    // selected data bit passes through combinationally; unselected bit is ignored
    d = 4'b1110;
    #1;
    check_model("r29sel");
    chk("r29_y_sel", {3'b000, y_o[0]}, 4'b0001);
    d = 4'b1111;
    #1;
    check_model("r29unsel");
    chk("r29_y_unsel", {3'b000, y_o[0]}, 4'b0001);
    d = 4'b1010;

    // lone requester held for 20 cycles, re-granted on each expiry
    for (int i = 0; i < 20; i++) begin
      cycle("r28hold");
      chk("r28_gnt", gnt_o[0], 4'b0100);
    end
    req = 4'b0000;
    cycle("r28drop");
    chk("r28_valid", {3'b000, valid_o[0]}, 4'b0000);

    // drop of requester 1 hands over to requester 3 with no bubble
    req = 4'b0010;
    cycle("r27a");
    chk("r27_gnt1", gnt_o[0], 4'b0010);
    req = 4'b1000;
    cycle("r27b");
    chk("r27_gnt3", gnt_o[0], 4'b1000);
    chk("r27_sel3", {2'b00, sel_o[0]}, 4'd3);
    chk("r27_valid", {3'b000, valid_o[0]}, 4'b0001);
    req = 4'b0000;
    cycle("r27idle");

    // all requesting: each grant lasts exactly 8 cycles in order 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      cycle("r26");
      chk($sformatf("r26_rot%0d", i), gnt_o[0], 4'b0001 << ((i / 8) % 4));
    end

    // random requests and data
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      d = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    // reset mid-grant between edges clears outputs immediately
    req = 4'b1111;
    cycle("r30a");
    cycle("r30b");
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("r30_gnt", gnt_o[0], 4'b0000);
    chk("r30_sel", {2'b00, sel_o[0]}, 4'd0);
    chk("r30_valid", {3'b000, valid_o[0]}, 4'b0000);
    chk("r30_y", {3'b000, y_o[0]}, 4'b0000);
    check_model("r30rst");
    req = 4'b1001;
    #1 rst_n = 1'b1;
    cycle("r30c");
    chk("r30_first", gnt_o[0], 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
